// File: rtl/irq_pkg.sv
// Shared definitions for the 8-source vectored interrupt controller:
// FSM state encoding, source-count constants and a one-hot helper.
package irq_pkg;

    localparam int N_SRC = 8;
    localparam int IDX_W = 3;

    // Index reported in the vector when an acknowledge finds nothing eligible.
    localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // One-hot decode of a source index.
    function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_encoder8.sv
// Combinational 8-input priority encoder: reports the index of the lowest
// set bit (bit 0 has highest priority) and a valid flag for non-zero input.
module priority_encoder8
    import irq_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last to assign idx.
    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        idx   = '0;
        valid = |req;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// 8-source vectored interrupt controller. Latches request edges (or follows
// levels), masks them, resolves fixed priority with source 0 highest, and
// runs a single-level INTA / EOI handshake with the CPU.
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter logic [7:0] VEC_BASE  = 8'h20,
    parameter bit         EDGE_TRIG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    input  logic       inta,
    input  logic       eoi,
    output logic       int_o,
    output logic [7:0] vector_o,
    output logic       vec_valid_o,
    output logic       spurious_o,
    output logic [7:0] irr_o,
    output logic [7:0] isr_o,
    output logic [7:0] mask_o
);

    logic [N_SRC-1:0] irr;
    logic [N_SRC-1:0] isr;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] irq_prev;
    state_t           state;

    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] grant_clr;
    logic [IDX_W-1:0] winner;
    logic             win_valid;
    logic             grant;

    // Requests that can compete this cycle; uses the mask as currently held,
    // so a mask write in the same cycle as a grant has not yet taken effect.
    assign eligible = irr & ~mask;
    assign rise     = irq & ~irq_prev;

    priority_encoder8 u_prio (
        .req   (eligible),
        .idx   (winner),
        .valid (win_valid)
    );

    // A grant happens only on an acknowledge in PEND with something eligible.
    assign grant     = (state == PEND) && inta && win_valid;
    assign grant_clr = grant ? onehot(winner) : '0;

    // Request latching: sticky edge capture, or a plain copy of the levels.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            irq_prev <= '0;
            irr      <= '0;
        end else begin
            irq_prev <= irq;
            if (EDGE_TRIG) begin
                // The set term is OR-ed in last so a fresh edge beats the grant clear.
                irr <= (irr & ~grant_clr) | rise;
            end else begin
                irr <= irq;
            end
        end
    end

    // Mask register; resets to all sources masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_din;
        end
    end

    // Handshake FSM with registered int/vector/strobe outputs and the in-service register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            isr         <= '0;
            int_o       <= 1'b0;
            vec_valid_o <= 1'b0;
            spurious_o  <= 1'b0;
            vector_o    <= '0;
        end else begin
            // Strobes are single-cycle; vector_o keeps its last value.
            vec_valid_o <= 1'b0;
            spurious_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state <= PEND;
                        int_o <= 1'b1;
                    end else begin
                        int_o <= 1'b0;
                    end
                end

                PEND: begin
                    if (inta && win_valid) begin
                        state       <= SERVICE;
                        isr         <= onehot(winner);
                        int_o       <= 1'b0;
                        vec_valid_o <= 1'b1;
                        vector_o    <= {VEC_BASE[7:3], winner};
                    end else if (inta) begin
                        // Request vanished between int_o and the acknowledge.
                        state       <= IDLE;
                        int_o       <= 1'b0;
                        vec_valid_o <= 1'b1;
                        spurious_o  <= 1'b1;
                        vector_o    <= {VEC_BASE[7:3], SPURIOUS_IDX};
                    end else if (!win_valid) begin
                        // Withdrawn or masked before the CPU acknowledged.
                        state <= IDLE;
                        int_o <= 1'b0;
                    end else begin
                        int_o <= 1'b1;
                    end
                end

                SERVICE: begin
                    int_o <= 1'b0;
                    if (eoi) begin
                        state <= IDLE;
                        isr   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    int_o <= 1'b0;
                    isr   <= '0;
                end
            endcase
        end
    end

    assign irr_o  = irr;
    assign isr_o  = isr;
    assign mask_o = mask;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed self-checking bench for irq_priority_ctrl (VEC_BASE=8'h20, edge mode).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_irq_priority_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_din;
    logic       inta;
    logic       eoi;
    logic       int_o;
    logic [7:0] vector_o;
    logic       vec_valid_o;
    logic       spurious_o;
    logic [7:0] irr_o;
    logic [7:0] isr_o;
    logic [7:0] mask_o;

    int errors = 0;
    int checks = 0;

    irq_priority_ctrl #(
        .VEC_BASE  (8'h20),
        .EDGE_TRIG (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .mask_we     (mask_we),
        .mask_din    (mask_din),
        .inta        (inta),
        .eoi         (eoi),
        .int_o       (int_o),
        .vector_o    (vector_o),
        .vec_valid_o (vec_valid_o),
        .spurious_o  (spurious_o),
        .irr_o       (irr_o),
        .isr_o       (isr_o),
        .mask_o      (mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        irq      = '0;
        mask_we  = 1'b0;
        mask_din = '0;
        inta     = 1'b0;
        eoi      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we  = 1'b1;
        mask_din = m;
        tick();
        mask_we  = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v;
        tick();
        irq = '0;
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        // ---- reset values ----
        do_reset();
        check("rst_int",      int_o,       8'h00);
        check("rst_vvalid",   vec_valid_o, 8'h00);
        check("rst_spur",     spurious_o,  8'h00);
        check("rst_vector",   vector_o,    8'h00);
        check("rst_irr",      irr_o,       8'h00);
        check("rst_isr",      isr_o,       8'h00);
        check("rst_mask",     mask_o,      8'hFF);

        // ---- single source 5 ----
        write_mask(8'h00);
        check("s1_mask",      mask_o,      8'h00);
        pulse_irq(8'h20);
        check("s1_irr",       irr_o,       8'h20);
        check("s1_int_early", int_o,       8'h00);
        tick();
        check("s1_int",       int_o,       8'h01);
        pulse_inta();
        check("s1_vvalid",    vec_valid_o, 8'h01);
        check("s1_vector",    vector_o,    8'h25);
        check("s1_spur",      spurious_o,  8'h00);
        check("s1_isr",       isr_o,       8'h20);
        check("s1_irr_clr",   irr_o,       8'h00);
        check("s1_int_drop",  int_o,       8'h00);
        tick();
        check("s1_vvalid_1c", vec_valid_o, 8'h00);
        check("s1_vec_hold",  vector_o,    8'h25);
        pulse_eoi();
        check("s1_isr_eoi",   isr_o,       8'h00);

        // ---- sources 6 and 2 together ----
        pulse_irq(8'h44);
        check("s2_irr",       irr_o,       8'h44);
        tick();
        check("s2_int",       int_o,       8'h01);
        pulse_inta();
        check("s2_vec1",      vector_o,    8'h22);
        check("s2_isr1",      isr_o,       8'h04);
        check("s2_irr1",      irr_o,       8'h40);
        tick();
        check("s2_int_svc",   int_o,       8'h00);
        pulse_eoi();
        check("s2_isr_eoi",   isr_o,       8'h00);
        check("s2_int_idle",  int_o,       8'h00);
        tick();
        check("s2_int_again", int_o,       8'h01);
        pulse_inta();
        check("s2_vec2",      vector_o,    8'h26);
        check("s2_isr2",      isr_o,       8'h40);
        check("s2_irr2",      irr_o,       8'h00);
        pulse_eoi();

        // ---- masked source 2, then unmask ----
        write_mask(8'h04);
        pulse_irq(8'h04);
        check("s3_irr",       irr_o,       8'h04);
        tick();
        tick();
        check("s3_int_masked", int_o,      8'h00);
        write_mask(8'h00);
        check("s3_int_lag",   int_o,       8'h00);
        tick();
        check("s3_int",       int_o,       8'h01);
        pulse_inta();
        check("s3_vector",    vector_o,    8'h22);
        pulse_eoi();

        // ---- spurious: source 3 masked while pending ----
        pulse_irq(8'h08);
        tick();
        check("s4_int",       int_o,       8'h01);
        write_mask(8'h08);
        check("s4_int_hold",  int_o,       8'h01);
        pulse_inta();
        check("s4_vvalid",    vec_valid_o, 8'h01);
        check("s4_spur",      spurious_o,  8'h01);
        check("s4_vector",    vector_o,    8'h27);
        check("s4_isr",       isr_o,       8'h00);
        check("s4_irr_kept",  irr_o,       8'h08);
        check("s4_int",       int_o,       8'h00);
        tick();
        check("s4_spur_1c",   spurious_o,  8'h00);
        pulse_inta();
        check("s4_inta_idle", vec_valid_o, 8'h00);
        check("s4_vec_hold",  vector_o,    8'h27);

        // ---- source 0 arriving during service of source 1 ----
        do_reset();
        write_mask(8'h00);
        pulse_irq(8'h02);
        tick();
        pulse_inta();
        check("s5_vec1",      vector_o,    8'h21);
        check("s5_isr1",      isr_o,       8'h02);
        pulse_irq(8'h01);
        check("s5_irr",       irr_o,       8'h01);
        check("s5_int_svc",   int_o,       8'h00);
        tick();
        tick();
        check("s5_int_svc2",  int_o,       8'h00);
        pulse_eoi();
        check("s5_isr_eoi",   isr_o,       8'h00);
        tick();
        check("s5_int",       int_o,       8'h01);
        pulse_inta();
        check("s5_vec2",      vector_o,    8'h20);
        check("s5_isr2",      isr_o,       8'h01);

        // ---- asynchronous reset while in service with irr=8'h10 ----
        pulse_irq(8'h10);
        check("s6_irr_pre",   irr_o,       8'h10);
        check("s6_isr_pre",   isr_o,       8'h01);
        rst = 1'b1;
        #2;
        check("s6_int",       int_o,       8'h00);
        check("s6_isr",       isr_o,       8'h00);
        check("s6_irr",       irr_o,       8'h00);
        check("s6_mask",      mask_o,      8'hFF);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
8-source vectored interrupt controller for the microcomputer CPU. It latches request edges, applies a mask, and resolves fixed priority, with source 0 highest. It raises a single interrupt line to the CPU and runs an acknowledge/end-of-interrupt handshake. It supplies the CPU with the vector of the winning source. One interrupt is in service at a time; there is no nesting.

Parameters:
VEC_BASE, 8'h20, vector base; vector_o = {VEC_BASE[7:3], idx[2:0]}; VEC_BASE[2:0] ignored
EDGE_TRIG, 1, 1 = rising-edge latched requests; 0 = level-sensitive (irr follows irq)

Ports:
clk  in  1  system clock
rst  in  1  reset
irq  in  8  request lines, synchronous to clk
mask_we  in  1  write strobe for mask register
mask_din  in  8  new mask value (1 = source masked)
inta  in  1  CPU acknowledge, one-cycle pulse
eoi  in  1  CPU end-of-interrupt, one-cycle pulse
int_o  out  1  interrupt request to CPU
vector_o  out  8  vector, valid when vec_valid_o=1
vec_valid_o  out  1  one-cycle strobe qualifying vector_o
spurious_o  out  1  set with vec_valid_o when no source was eligible at acknowledge
irr_o  out  8  pending-request register (status)
isr_o  out  8  in-service register (status, at most one bit set)
mask_o  out  8  mask register readback

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - mask = 8'hFF; irr, isr, irq_prev = 0.
  - int_o, vec_valid_o, spurious_o = 0; vector_o = 0.
  - State = IDLE.
- Request latching, EDGE_TRIG=1:
  - irr[i] is set on the cycle after irq[i]=1 with irq_prev[i]=0.
  - irr[i] stays set until granted. Masking does not clear irr.
  - A new edge on the same cycle as a grant-clear of that bit: set wins.
- Request latching, EDGE_TRIG=0: irr <= irq every cycle; grant-clear has no effect.
- Mask: on mask_we, mask <= mask_din the next cycle. A grant in the same cycle uses the old mask.
- eligible = irr & ~mask.
- winner = lowest index set in eligible, produced by combinational priority resolution.
- FSM IDLE:
  - int_o=0.
  - If eligible != 0, go to PEND; int_o=1 from the next cycle (1-cycle latency from irr to int_o).
- FSM PEND:
  - int_o=1.
  - If inta=1 and eligible != 0:
    - capture winner; clear irr[winner]; set isr[winner].
    - Next cycle: vec_valid_o=1 for exactly one cycle, vector_o = {VEC_BASE[7:3], winner}, int_o=0.
    - Go to SERVICE.
  - Else if inta=1 and eligible == 0:
    - Next cycle: vec_valid_o=1, spurious_o=1, vector_o = {VEC_BASE[7:3], 3'd7}.
    - isr unchanged; go to IDLE.
  - Else if eligible == 0 (withdrawn or masked): go to IDLE; int_o=0 next cycle.
- FSM SERVICE:
  - int_o=0; new edges continue to latch into irr.
  - On eoi=1: clear isr; go to IDLE. New pending requests re-raise int_o after one IDLE cycle.
- eoi in IDLE or PEND is ignored.
- inta outside PEND is ignored; no vec_valid_o.
- vector_o holds its last value between strobes. spurious_o is only meaningful with vec_valid_o and is 0 otherwise.
- rst mid-operation: all state returns to reset values immediately; any in-progress service is abandoned.

Decomposition:
- Shared package irq_pkg:
  - FSM state encoding (IDLE=2'd0, PEND=2'd1, SERVICE=2'd2).
  - N_SRC=8, IDX_W=3.
  - SPURIOUS_IDX=3'd7.
- One sub-module: priority_encoder8.
  - Combinational; 8-bit input; outputs 3-bit index of the lowest set bit plus a valid flag.
  - Handles multi-hot inputs.
  - Instantiated once, on eligible.

Test Plan:
- Reset, then mask_din=8'h00, then an irq[5] pulse → irr_o=8'h20 and int_o=1 two cycles after the edge; inta → next cycle vec_valid_o=1, vector_o=8'h25, isr_o=8'h20, irr_o=0; eoi → isr_o=0.
- irq[6] and irq[2] rising in the same cycle, mask=0 → first inta gives vector 8'h22; after eoi, int_o re-asserts; second inta gives 8'h26.
- With mask=8'h04, an irq[2] edge → irr_o=8'h04 and int_o stays 0; write mask=8'h00 → int_o=1; inta gives 8'h22.
- Enter PEND with source 3, write mask=8'h08 and pulse inta in the next cycle → vec_valid_o=1, spurious_o=1, vector_o=8'h27, isr_o=0, state IDLE.
- During SERVICE of source 1, an irq[0] edge → int_o stays 0 until eoi; after eoi, int_o=1 and inta gives 8'h20.
- Assert rst while in SERVICE with irr=8'h10 → int_o=0, isr_o=0, irr_o=0, mask_o=8'hFF immediately, before the next clk edge.
